// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the memory port.
// master: the arbiter's view (it drives the memory request side).
// slave:  the surrounding system's view (masters and memory).
interface mem_arbiter_if #(
  parameter int unsigned WIDTH = 32
);

  logic             i_pa_request;
  logic             i_pa_rw;
  logic [31:0]      i_pa_address;
  logic [WIDTH-1:0] i_pa_wdata;
  logic [WIDTH-1:0] o_pa_rdata;
  logic             o_pa_ready;
  logic             o_pa_valid;

  logic             i_pb_request;
  logic             i_pb_rw;
  logic [31:0]      i_pb_address;
  logic [WIDTH-1:0] i_pb_wdata;
  logic [WIDTH-1:0] o_pb_rdata;
  logic             o_pb_ready;
  logic             o_pb_valid;

  logic             o_request;
  logic             o_rw;
  logic [31:0]      o_address;
  logic [WIDTH-1:0] o_wdata;
  logic [WIDTH-1:0] i_rdata;
  logic             i_ready;
  logic             i_valid;
  logic             o_timeout;

  modport master (
    input  i_pa_request, i_pa_rw, i_pa_address, i_pa_wdata,
    input  i_pb_request, i_pb_rw, i_pb_address, i_pb_wdata,
    output o_pa_rdata, o_pa_ready, o_pa_valid,
    output o_pb_rdata, o_pb_ready, o_pb_valid,
    output o_request, o_rw, o_address, o_wdata, o_timeout,
    input  i_rdata, i_ready, i_valid
  );

  modport slave (
    output i_pa_request, i_pa_rw, i_pa_address, i_pa_wdata,
    output i_pb_request, i_pb_rw, i_pb_address, i_pb_wdata,
    input  o_pa_rdata, o_pa_ready, o_pa_valid,
    input  o_pb_rdata, o_pb_ready, o_pb_valid,
    input  o_request, o_rw, o_address, o_wdata, o_timeout,
    output i_rdata, i_ready, i_valid
  );

endinterface

// File: rtl/mem_arbiter_timeout_counter.sv
// Counts stalled cycles of a granted access; expired marks the last allowed one.
module mem_arbiter_timeout_counter #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = (LIMIT == 0) ? 16'd0 : 16'(LIMIT - 1);

  logic [15:0] count;

  // Stall counter, cleared whenever no access is in flight
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // A LIMIT of zero disables expiry entirely
  assign expired = (LIMIT != 0) && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two request/ready masters onto one latency memory port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  mem_arbiter_if.master bus
);

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             last_grant_nxt;
  logic             sel_b;
  logic             busy;
  logic             owner_req;
  logic             expired;
  logic             expire_hit;
  logic [WIDTH-1:0] wdata_mux;

  assign sel_b     = (state == BUSY_B);
  assign busy      = (state == BUSY_A) || (state == BUSY_B);
  assign owner_req = sel_b ? bus.i_pb_request : bus.i_pa_request;
  // A completion on the expiry cycle wins; an aborted request never times out
  assign expire_hit = busy && owner_req && !bus.i_ready && expired;

  mem_arbiter_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .clear     (!busy),
    .enable    (busy && !bus.i_ready),
    .expired   (expired)
  );

  // State and round-robin history registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      last_grant <= GRANT_B;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Grant decision and transaction sequencing
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (bus.i_pa_request && (!bus.i_pb_request || last_grant == GRANT_B)) begin
          state_nxt      = BUSY_A;
          last_grant_nxt = GRANT_A;
        end else if (bus.i_pb_request) begin
          state_nxt      = BUSY_B;
          last_grant_nxt = GRANT_B;
        end
      end
      BUSY_A: begin
        if (!bus.i_pa_request || bus.i_ready || expired) state_nxt = GAP;
      end
      BUSY_B: begin
        if (!bus.i_pb_request || bus.i_ready || expired) state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wdata_mux     = sel_b ? bus.i_pb_wdata : bus.i_pa_wdata;
  assign bus.o_request = busy;
  assign bus.o_rw      = sel_b ? bus.i_pb_rw : bus.i_pa_rw;
  assign bus.o_address = sel_b ? bus.i_pb_address : bus.i_pa_address;
  assign bus.o_wdata   = wdata_mux;

  assign bus.o_pa_rdata = bus.i_rdata;
  assign bus.o_pb_rdata = bus.i_rdata;

  assign bus.o_pa_ready = (state == BUSY_A) && bus.i_pa_request && (bus.i_ready || expired);
  assign bus.o_pb_ready = (state == BUSY_B) && bus.i_pb_request && (bus.i_ready || expired);
  assign bus.o_pa_valid = (state != BUSY_A) || (bus.i_valid && !expire_hit);
  assign bus.o_pb_valid = (state != BUSY_B) || (bus.i_valid && !expire_hit);
  assign bus.o_timeout  = expire_hit;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned LAT     = 2;
  localparam int unsigned SIZE    = 64;

  logic i_clock = 1'b0;
  logic i_reset_n;
  always #5 i_clock = ~i_clock;

  mem_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mem_arbiter #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  // Memory environment: ready once the held request has been counted LAT times
  bit [31:0]   mem [SIZE];
  int unsigned mcnt;
  bit          stall;

  always @(posedge i_clock) begin
    mcnt <= bus.o_request ? mcnt + 1 : 0;
    if (bus.o_request && bus.i_ready && bus.o_rw && bus.i_valid)
      mem[bus.o_address[7:2]] <= bus.o_wdata;
  end

  assign bus.i_ready = bus.o_request && (mcnt == LAT) && !stall;
  assign bus.i_valid = bus.o_address < 32'(SIZE * 4);
  assign bus.i_rdata = bus.i_valid ? mem[bus.o_address[7:2]] : '0;

  // Request-line activity monitor
  int run_hi, last_run, low_run, to_cnt;
  int min_gap = 1000;
  bit seen_hi;

  always @(negedge i_clock) begin
    to_cnt <= to_cnt + (bus.o_timeout ? 1 : 0);
    if (bus.o_request) begin
      if (seen_hi && low_run > 0 && low_run < min_gap) min_gap <= low_run;
      low_run <= 0;
      run_hi  <= run_hi + 1;
      seen_hi <= 1'b1;
    end else begin
      if (run_hi > 0) last_run <= run_hi;
      run_hi  <= 0;
      low_run <= low_run + 1;
    end
  end

  int vec_cnt, err_cnt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference state: pending transaction per master, memory image, last served master
  logic        t_rw   [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wd   [2];
  bit   [31:0] ref_mem [SIZE];
  int          last;

  task automatic drive(input int m, input bit req);
    if (m == 0) begin
      bus.i_pa_request = req;
      bus.i_pa_rw      = t_rw[0];
      bus.i_pa_address = t_addr[0];
      bus.i_pa_wdata   = t_wd[0];
    end else begin
      bus.i_pb_request = req;
      bus.i_pb_rw      = t_rw[1];
      bus.i_pb_address = t_addr[1];
      bus.i_pb_wdata   = t_wd[1];
    end
  endtask

  task automatic set_txn(input int m, input logic rw, input logic [31:0] addr, input logic [31:0] wd);
    t_rw[m]   = rw;
    t_addr[m] = addr;
    t_wd[m]   = wd;
  endtask

  // Wait for master m's completion, check it, then withdraw m's request
  task automatic serve(input int m, input int exp_cyc, input string tag, output logic [31:0] rd);
    int   n;
    bit   exp_valid;
    logic got_valid;
    n  = 0;
    rd = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge i_clock);
      if (bus.o_pa_ready || bus.o_pb_ready) begin
        n = i;
        break;
      end
    end
    check_eq({tag, "_latency"}, 64'(n), 64'(exp_cyc));
    if (n == 0) return;
    exp_valid = t_addr[m] < 32'(SIZE * 4);
    got_valid = (m == 1) ? bus.o_pb_valid : bus.o_pa_valid;
    rd        = (m == 1) ? bus.o_pb_rdata : bus.o_pa_rdata;
    check_eq({tag, "_who"}, {bus.o_pb_ready, bus.o_pa_ready}, (m == 1) ? 2'b10 : 2'b01);
    check_eq({tag, "_addr"}, bus.o_address, t_addr[m]);
    check_eq({tag, "_rw"}, bus.o_rw, t_rw[m]);
    check_eq({tag, "_valid"}, got_valid, exp_valid);
    check_eq({tag, "_tmo"}, bus.o_timeout, 1'b0);
    if (exp_valid && !t_rw[m]) check_eq({tag, "_rdata"}, rd, ref_mem[t_addr[m][7:2]]);
    if (t_rw[m]) check_eq({tag, "_wdata"}, bus.o_wdata, t_wd[m]);
    if (exp_valid && t_rw[m]) ref_mem[t_addr[m][7:2]] = t_wd[m];
    last = m;
    @(posedge i_clock);
    #1;
    drive(m, 1'b0);
  endtask

  task automatic rand_txn(input int m);
    t_rw[m]   = 1'($urandom_range(0, 1));
    t_addr[m] = ($urandom_range(0, 9) == 0) ? 32'h400 + 32'($urandom_range(0, 255)) * 4
                                            : 32'($urandom_range(0, 15)) * 4;
    t_wd[m]   = $urandom;
  endtask

  // One arbitration round starting from IDLE; ends back in IDLE
  task automatic rand_round();
    bit          ra, rb;
    int          first;
    logic [31:0] rd;
    ra = 1'($urandom_range(0, 1));
    rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
    rand_txn(0);
    rand_txn(1);
    drive(0, ra);
    drive(1, rb);
    if (ra && rb) begin
      first = (last == 0) ? 1 : 0;
      serve(first, LAT + 2, "rnd_first", rd);
      serve(1 - first, LAT + 3, "rnd_second", rd);
    end else begin
      serve(ra ? 0 : 1, LAT + 2, "rnd_single", rd);
    end
    @(posedge i_clock);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    int          n;
    i_reset_n = 1'b0;
    stall     = 1'b0;
    last      = 1;
    set_txn(0, 1'b0, 32'h44, 32'h0);
    set_txn(1, 1'b0, 32'h88, 32'h0);
    drive(0, 1'b0);
    drive(1, 1'b0);

    #12;
    check_eq("rst_request", bus.o_request, 1'b0);
    check_eq("rst_readies", {bus.o_pa_ready, bus.o_pb_ready}, 2'b00);
    check_eq("rst_timeout", bus.o_timeout, 1'b0);
    check_eq("rst_valids", {bus.o_pa_valid, bus.o_pb_valid}, 2'b11);
    check_eq("rst_mux_a", bus.o_address, 32'h44);
    #10 i_reset_n = 1'b1;
    @(negedge i_clock);
    check_eq("idle_request", bus.o_request, 1'b0);
    @(posedge i_clock);
    #1;

    // Both masters from reset: A first, then alternation over four transactions
    for (int r = 0; r < 2; r++) begin
      set_txn(0, 1'b0, 32'($urandom_range(0, 15)) * 4, 32'h0);
      set_txn(1, 1'b0, 32'($urandom_range(0, 15)) * 4, 32'h0);
      drive(0, 1'b1);
      drive(1, 1'b1);
      serve(0, LAT + 2, "alt_a", rd);
      serve(1, LAT + 3, "alt_b", rd);
      @(posedge i_clock);
      #1;
    end

    // Single read by A at 0x10
    set_txn(0, 1'b0, 32'h10, 32'h0);
    drive(0, 1'b1);
    serve(0, LAT + 2, "single_a", rd);
    @(posedge i_clock);
    #1;
    check_eq("single_req_len", 64'(last_run), 64'(LAT + 1));

    // B writes, A reads back
    set_txn(1, 1'b1, 32'h20, 32'hDEADBEEF);
    drive(1, 1'b1);
    serve(1, LAT + 2, "wr_b", rd);
    @(posedge i_clock);
    #1;
    set_txn(0, 1'b0, 32'h20, 32'h0);
    drive(0, 1'b1);
    serve(0, LAT + 2, "rd_a", rd);
    check_eq("rd_a_deadbeef", rd, 32'hDEADBEEF);
    @(posedge i_clock);
    #1;

    // Out-of-range read by A
    set_txn(0, 1'b0, 32'h400, 32'h0);
    drive(0, 1'b1);
    serve(0, LAT + 2, "oor_a", rd);
    @(posedge i_clock);
    #1;

    // Timeout on B with the memory stalled
    stall = 1'b1;
    set_txn(1, 1'b0, 32'h8, 32'h0);
    drive(1, 1'b1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge i_clock);
      if (bus.o_pa_ready || bus.o_pb_ready) begin
        n = i;
        break;
      end
    end
    check_eq("tmo_latency", 64'(n), 64'(TIMEOUT + 1));
    check_eq("tmo_ready", {bus.o_pb_ready, bus.o_pa_ready}, 2'b10);
    check_eq("tmo_valid", bus.o_pb_valid, 1'b0);
    check_eq("tmo_pulse", bus.o_timeout, 1'b1);
    last = 1;
    @(posedge i_clock);
    #1;
    drive(1, 1'b0);
    @(negedge i_clock);
    check_eq("tmo_gap_pulse", bus.o_timeout, 1'b0);
    check_eq("tmo_gap_req", bus.o_request, 1'b0);
    @(negedge i_clock);
    check_eq("tmo_idle_req", bus.o_request, 1'b0);
    stall = 1'b0;
    @(posedge i_clock);
    #1;

    // A withdraws its request before completion
    set_txn(0, 1'b0, 32'h4, 32'h0);
    drive(0, 1'b1);
    @(posedge i_clock);
    #1;
    @(posedge i_clock);
    #1;
    drive(0, 1'b0);
    last = 0;
    @(negedge i_clock);
    check_eq("abort_noready", {bus.o_pb_ready, bus.o_pa_ready}, 2'b00);
    @(negedge i_clock);
    check_eq("abort_gap_req", bus.o_request, 1'b0);
    @(posedge i_clock);
    #1;

    // Reset in the middle of an A access
    set_txn(0, 1'b0, 32'hC, 32'h0);
    drive(0, 1'b1);
    @(posedge i_clock);
    #1;
    @(posedge i_clock);
    #1;
    check_eq("pre_rst_req", bus.o_request, 1'b1);
    #2 i_reset_n = 1'b0;
    drive(0, 1'b0);
    last = 1;
    #1;
    check_eq("async_rst_req", bus.o_request, 1'b0);
    #3 i_reset_n = 1'b1;
    @(posedge i_clock);
    #1;
    set_txn(1, 1'b0, 32'h20, 32'h0);
    drive(1, 1'b1);
    @(posedge i_clock);
    #1;
    check_eq("post_rst_grant", bus.o_request, 1'b1);
    serve(1, LAT + 1, "post_rst_b", rd);
    @(posedge i_clock);
    #1;

    for (int r = 0; r < 60; r++) rand_round();

    @(negedge i_clock);
    check_eq("timeout_count", 64'(to_cnt), 64'd1);
    check_eq("min_req_gap", 64'(min_gap), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master round-robin arbiter sitting directly upstream of a single-port latency memory (BRAM with request/ready handshake). It multiplexes two request/ready masters, typically instruction fetch and data load/store, onto the memory's one request port. It enforces the memory's one-cycle request-low gap between transactions, which resets the memory's latency counter, and bounds every access with a timeout.

## Interface
- WIDTH, 32, data width of wdata/rdata.
- TIMEOUT, 1024, max cycles a granted request may wait for ready; 0 disables the timeout.

- i_clock  in  1  clock, all state on rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_pa_request / i_pb_request  in  1  master A/B request; held with fields stable until ready.
- i_pa_rw / i_pb_rw  in  1  0 = read, 1 = write.
- i_pa_address / i_pb_address  in  32  byte address.
- i_pa_wdata / i_pb_wdata  in  WIDTH  write data.
- o_pa_rdata / o_pb_rdata  out  WIDTH  read data, broadcast copy of i_rdata.
- o_pa_ready / o_pb_ready  out  1  transaction complete for that master, single-cycle pulse.
- o_pa_valid / o_pb_valid  out  1  access status, meaningful when the matching ready is high; 0 = out of range or timed out.
- o_request  out  1  request to memory.
- o_rw  out  1  muxed rw.
- o_address  out  32  muxed address.
- o_wdata  out  WIDTH  muxed wdata.
- i_rdata  in  WIDTH  memory read data.
- i_ready  in  1  memory completion; may be combinational from o_request.
- i_valid  in  1  memory address-in-range flag.
- o_timeout  out  1  one-cycle pulse when a transaction is aborted by timeout.

## Operation
- FSM states: IDLE, BUSY_A, BUSY_B, GAP.
- Reset state is IDLE, with last_grant = B so A wins the first tie. Timeout counter resets to 0.
- Reset values of outputs: o_request = 0, both readies 0, o_timeout 0, both valids 1. o_rw, o_address and o_wdata follow the mux select, which defaults to A.
- IDLE:
  - Only A requesting -> BUSY_A. Only B requesting -> BUSY_B.
  - Both requesting -> grant the master that is not last_grant, then update last_grant.
  - No request -> stay in IDLE.
- BUSY_x:
  - o_request = 1. Downstream fields come combinationally from master x.
  - o_px_ready = i_ready. o_px_valid = i_valid.
  - The other master's ready is 0.
  - On i_ready -> GAP.
- Abort from BUSY_x: if master x drops its request before i_ready -> GAP with no ready pulse.
- Timeout from BUSY_x (TIMEOUT > 0 only):
  - The counter increments each BUSY cycle without i_ready.
  - When the counter equals TIMEOUT-1 and i_ready is low: pulse o_px_ready = 1 with o_px_valid = 0, pulse o_timeout, then -> GAP.
- GAP: o_request = 0 for exactly one cycle, the counter clears, then -> IDLE.
- Arbitration fairness: with both masters continuously re-requesting, grants strictly alternate A, B, A, B.
- Simultaneous events: i_ready and the timeout on the same cycle resolve as a normal completion (valid = i_valid, no o_timeout).
- Reset mid-transaction: o_request drops asynchronously and the FSM returns to IDLE. A partially latched memory write is the memory's concern; the arbiter does not re-issue it.

## Timing
- Request sampling latency: a master request seen in IDLE at edge N gives o_request = 1 in cycle N+1.
- Completion: o_px_ready is combinational with i_ready, so there is zero added completion latency.
- Per-transaction occupancy: 1 (IDLE decision) + memory cycles until ready + 1 (GAP).
- Against a memory with LATENCY = L (ready when its held-request counter reaches L): o_request is high for L+1 cycles, so a single access costs L+3 cycles.
- Masters must deassert their request for at least one cycle after their ready pulse. A request held high after its ready is treated as a new transaction at the next IDLE.
- The counter is 16 bits wide. TIMEOUT must be ≤ 65535.

## Structure
- Package mem_arbiter_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, BUSY_A, BUSY_B, GAP}.
  - Constants GRANT_A = 1'b0 and GRANT_B = 1'b1.
- Optional sub-module timeout_counter (parameter LIMIT; ports clear, enable, expired) holds the timeout logic. Everything else lives in one module.

## Test plan
- Single read, A only, memory LATENCY = 2, address 0x10 -> o_request high 3 cycles, o_pa_ready one pulse carrying the memory word, next o_request no earlier than 2 cycles later.
- A and B assert together from reset -> A granted first; both held and re-requesting -> grant order A, B, A, B over 4 transactions.
- B writes 0xDEADBEEF to 0x20, then A reads 0x20 -> A receives 0xDEADBEEF with o_pa_valid = 1.
- A reads an address beyond SIZE -> o_pa_ready pulses with o_pa_valid = 0, no o_timeout.
- TIMEOUT = 8 with i_ready tied low -> after 8 BUSY cycles o_pb_ready = 1, o_pb_valid = 0, o_timeout = 1 for one cycle, then GAP, then IDLE.
- Assert i_reset_n low during BUSY_A -> o_request = 0 immediately. After release, B requesting alone is granted within 1 cycle.
